// File: rtl/cp0_pkg.sv
// cp0_pkg
// Shared definitions for the coprocessor-0 slice: register addresses,
// exception codes, the bit positions of the Status/Cause fields, the mask of
// writable Status bits and the exception-priority helper.
package cp0_pkg;

  // Register numbers as seen by mtc0/mfc0
  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  // ExcCode values written into Cause when an exception is taken
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_BP  = 5'd9,
    EXC_RI  = 5'd10,
    EXC_OV  = 5'd12
  } excCode_e;

  // Status field positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;

  // Cause field positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  // Only IM, EXL and IE exist in Status
  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

  // Picks the ExcCode of the highest-priority active source. The caller
  // only uses the result when at least one source is active, so overflow is
  // the fall-through case.
  function automatic excCode_e selectExcCode(input logic intPending,
                                             input logic ri,
                                             input logic sys,
                                             input logic brk);
    excCode_e code;
    if (intPending)  code = EXC_INT;
    else if (ri)     code = EXC_RI;
    else if (sys)    code = EXC_SYS;
    else if (brk)    code = EXC_BP;
    else             code = EXC_OV;
    return code;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer
// Count/Compare timer with the timer-interrupt flag TI.
// Ports:
//   clk, rstn        clock and synchronous active-low reset
//   countWe_i        load Count from wData_i instead of incrementing
//   compareWe_i      load Compare from wData_i and clear TI
//   wData_i          mtc0 write data
//   count_o          current Count
//   compare_o        current Compare
//   ti_o             timer interrupt flag
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        countWe_i,
  input  logic        compareWe_i,
  input  logic [31:0] wData_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] countQ, countD;
  logic [31:0] compareQ, compareD;
  logic        tiQ, tiD;

  // Count free-runs (wrapping naturally at 32 bits) unless software loads
  // it. TI is raised when the value Count is about to take equals Compare;
  // a Compare write clears TI and beats a match on the same edge.
  always_comb begin
    countD   = countWe_i ? wData_i : countQ + 32'd1;
    compareD = compareWe_i ? wData_i : compareQ;
    tiD      = tiQ;
    if (compareWe_i) begin
      tiD = 1'b0;
    end else if (countD == compareQ) begin
      tiD = 1'b1;
    end
  end

  // Timer state register; reset parks Compare at all-ones
  always_ff @(posedge clk) begin
    if (!rstn) begin
      countQ   <= 32'd0;
      compareQ <= 32'hFFFF_FFFF;
      tiQ      <= 1'b0;
    end else begin
      countQ   <= countD;
      compareQ <= compareD;
      tiQ      <= tiD;
    end
  end

  assign count_o   = countQ;
  assign compare_o = compareQ;
  assign ti_o      = tiQ;

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit
// Coprocessor 0: Status, Cause, EPC plus the Count/Compare timer, exception
// and interrupt entry, eret and the fetch redirect.
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   excOverflow/excSyscall/
//   excBreak/excRI                 synchronous exceptions of the EX instruction
//   intReq[5:0]                    level hardware interrupts HW0..HW5
//   instrPC, inDelaySlot           PC and delay-slot flag of the EX instruction
//   stall                          EX held: no exception entry, mtc0 or eret
//   we, wAddr, din                 mtc0 write port
//   rAddr, dout                    mfc0 combinational read port
//   eret                           EX instruction is eret
//   redirect, redirectPC           flush/refetch request and its target
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        excOverflow,
  input  logic        excSyscall,
  input  logic        excBreak,
  input  logic        excRI,
  input  logic [5:0]  intReq,
  input  logic [31:0] instrPC,
  input  logic        inDelaySlot,
  input  logic        stall,
  input  logic        we,
  input  logic [4:0]  wAddr,
  input  logic [31:0] din,
  input  logic [4:0]  rAddr,
  output logic [31:0] dout,
  input  logic        eret,
  output logic        redirect,
  output logic [31:0] redirectPC
);

  logic [7:0]  imQ, imD;
  logic        exlQ, exlD;
  logic        ieQ, ieD;
  logic        bdQ, bdD;
  excCode_e    excCodeQ, excCodeD;
  logic [1:0]  ipSwQ, ipSwD;
  logic [31:0] epcQ, epcD;

  logic [31:0] count, compare;
  logic        ti;

  logic [7:0]  ip;
  logic        intPending;
  logic        anyExc;
  logic        takeExc;
  logic        takeEret;
  logic        wrEn;
  excCode_e    excCode;
  logic [31:0] statusWord;
  logic [31:0] causeWord;

  // Hardware IP bits follow the interrupt lines directly; IP7 is shared
  // with the timer. An interrupt is only pending with IE set, outside
  // exception level, and with a matching mask bit.
  always_comb begin
    ip         = {intReq[5] | ti, intReq[4:0], ipSwQ};
    intPending = ieQ & ~exlQ & (|(ip & imQ));
    anyExc     = intPending | excRI | excSyscall | excBreak | excOverflow;
    takeExc    = rstn & ~stall & anyExc;
    takeEret   = rstn & ~stall & eret & ~anyExc;
    wrEn       = rstn & ~stall & we;
    excCode    = selectExcCode(intPending, excRI, excSyscall, excBreak);
  end

  // The redirect goes out in the same cycle the cause is seen; an
  // exception always beats a simultaneous eret.
  always_comb begin
    redirect   = takeExc | takeEret;
    redirectPC = takeExc ? EXC_VECTOR : epcQ;
  end

  // Next-state for Status/Cause/EPC. The mtc0 effect is applied first so
  // that exception entry or eret, applied after, overrides only the fields
  // it owns while the other written bits still land. EPC and BD are frozen
  // for nested exceptions taken while EXL is already set.
  always_comb begin
    imD      = imQ;
    exlD     = exlQ;
    ieD      = ieQ;
    bdD      = bdQ;
    excCodeD = excCodeQ;
    ipSwD    = ipSwQ;
    epcD     = epcQ;

    if (wrEn) begin
      case (wAddr)
        ADDR_STATUS: begin
          imD  = din[STATUS_IM_HI:STATUS_IM_LO];
          exlD = din[STATUS_EXL];
          ieD  = din[STATUS_IE];
        end
        ADDR_CAUSE: ipSwD = din[CAUSE_IP_LO+1:CAUSE_IP_LO];
        ADDR_EPC:   epcD  = din;
        default: ;
      endcase
    end

    if (takeExc) begin
      exlD     = 1'b1;
      excCodeD = excCode;
      if (!exlQ) begin
        bdD  = inDelaySlot;
        epcD = inDelaySlot ? instrPC - 32'd4 : instrPC;
      end
    end else if (takeEret) begin
      exlD = 1'b0;
    end
  end

  // Architectural register state; reset wins over everything else
  always_ff @(posedge clk) begin
    if (!rstn) begin
      imQ      <= RESET_STATUS[STATUS_IM_HI:STATUS_IM_LO];
      exlQ     <= RESET_STATUS[STATUS_EXL];
      ieQ      <= RESET_STATUS[STATUS_IE];
      bdQ      <= 1'b0;
      excCodeQ <= EXC_INT;
      ipSwQ    <= 2'b00;
      epcQ     <= 32'd0;
    end else begin
      imQ      <= imD;
      exlQ     <= exlD;
      ieQ      <= ieD;
      bdQ      <= bdD;
      excCodeQ <= excCodeD;
      ipSwQ    <= ipSwD;
      epcQ     <= epcD;
    end
  end

  cp0_timer u_timer (
    .clk         (clk),
    .rstn        (rstn),
    .countWe_i   (wrEn && (wAddr == ADDR_COUNT)),
    .compareWe_i (wrEn && (wAddr == ADDR_COMPARE)),
    .wData_i     (din),
    .count_o     (count),
    .compare_o   (compare),
    .ti_o        (ti)
  );

  // Assemble the architectural register images; unimplemented bits are 0
  always_comb begin
    statusWord = '0;
    statusWord[STATUS_IM_HI:STATUS_IM_LO] = imQ;
    statusWord[STATUS_EXL] = exlQ;
    statusWord[STATUS_IE]  = ieQ;

    causeWord = '0;
    causeWord[CAUSE_BD] = bdQ;
    causeWord[CAUSE_TI] = ti;
    causeWord[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
    causeWord[CAUSE_EXC_HI:CAUSE_EXC_LO] = excCodeQ;
  end

  // mfc0 read mux of the current (pre-edge) state
  always_comb begin
    dout = '0;
    case (rAddr)
      ADDR_COUNT:   dout = count;
      ADDR_COMPARE: dout = compare;
      ADDR_STATUS:  dout = statusWord;
      ADDR_CAUSE:   dout = causeWord;
      ADDR_EPC:     dout = epcQ;
      default:      dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit
// Directed scenarios plus a randomized run of cp0_unit checked against an
// architectural model of the CP0 registers kept as plain 32-bit words.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        excOverflow, excSyscall, excBreak, excRI;
  logic [5:0]  intReq;
  logic [31:0] instrPC;
  logic        inDelaySlot;
  logic        stall;
  logic        we;
  logic [4:0]  wAddr;
  logic [31:0] din;
  logic [4:0]  rAddr;
  logic [31:0] dout;
  logic        eret;
  logic        redirect;
  logic [31:0] redirectPC;

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic [31:0] mStatus, mEpc, mCount, mCompare;
  logic        mBd, mTi;
  logic [4:0]  mExc;
  logic [1:0]  mIpSw;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .excOverflow (excOverflow),
    .excSyscall  (excSyscall),
    .excBreak    (excBreak),
    .excRI       (excRI),
    .intReq      (intReq),
    .instrPC     (instrPC),
    .inDelaySlot (inDelaySlot),
    .stall       (stall),
    .we          (we),
    .wAddr       (wAddr),
    .din         (din),
    .rAddr       (rAddr),
    .dout        (dout),
    .eret        (eret),
    .redirect    (redirect),
    .redirectPC  (redirectPC)
  );

  // Model helpers: interrupt-pending and whether exception/eret is taken
  function automatic logic [7:0] mIp();
    return {intReq[5] | mTi, intReq[4:0], mIpSw};
  endfunction

  function automatic logic mPending();
    return mStatus[0] && !mStatus[1] && ((mIp() & mStatus[15:8]) != 8'd0);
  endfunction

  function automatic logic mAnySrc();
    return mPending() || excRI || excSyscall || excBreak || excOverflow;
  endfunction

  function automatic logic mTakeExc();
    return rstn && !stall && mAnySrc();
  endfunction

  function automatic logic mTakeEret();
    return rstn && !stall && eret && !mAnySrc();
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    case (a)
      5'd9:    return mCount;
      5'd11:   return mCompare;
      5'd12:   return mStatus;
      5'd13:   return {mBd, mTi, 14'd0, mIp(), 1'b0, mExc, 2'b00};
      5'd14:   return mEpc;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic modelEdge();
    logic        take, doEret, oldExl, wr;
    logic [4:0]  code;
    logic [31:0] nextCount;
    if (!rstn) begin
      mStatus  = 32'd0;
      mBd      = 1'b0;
      mTi      = 1'b0;
      mExc     = 5'd0;
      mIpSw    = 2'b00;
      mEpc     = 32'd0;
      mCount   = 32'd0;
      mCompare = 32'hFFFF_FFFF;
    end else begin
      take   = mTakeExc();
      doEret = mTakeEret();
      oldExl = mStatus[1];
      wr     = we && !stall;
      if (mPending())      code = 5'd0;
      else if (excRI)      code = 5'd10;
      else if (excSyscall) code = 5'd8;
      else if (excBreak)   code = 5'd9;
      else                 code = 5'd12;

      nextCount = (wr && wAddr == 5'd9) ? din : mCount + 1;
      if (wr && wAddr == 5'd11)       mTi = 1'b0;
      else if (nextCount == mCompare) mTi = 1'b1;
      if (wr && wAddr == 5'd11) mCompare = din;
      mCount = nextCount;

      if (wr && wAddr == 5'd12) mStatus = din & 32'h0000_FF03;
      if (wr && wAddr == 5'd13) mIpSw = din[9:8];
      if (wr && wAddr == 5'd14) mEpc = din;

      if (take) begin
        mStatus = mStatus | 32'h2;
        mExc    = code;
        if (!oldExl) begin
          mBd  = inDelaySlot;
          mEpc = inDelaySlot ? instrPC - 4 : instrPC;
        end
      end else if (doEret) begin
        mStatus = mStatus & ~32'h2;
      end
    end
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle();
    rstn        = 1'b1;
    excOverflow = 1'b0;
    excSyscall  = 1'b0;
    excBreak    = 1'b0;
    excRI       = 1'b0;
    intReq      = 6'd0;
    instrPC     = 32'd0;
    inDelaySlot = 1'b0;
    stall       = 1'b0;
    we          = 1'b0;
    wAddr       = 5'd0;
    din         = 32'd0;
    rAddr       = 5'd0;
    eret        = 1'b0;
  endtask

  task automatic doReset();
    applyIdle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Reset values of every implemented register
  task automatic test_reset();
    doReset();
    #1;
    checks++;
    if (redirect !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_redirect got %b exp 0", redirect);
    end
    rAddr = 5'd12; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL reset_status got %h exp 0", dout); end
    rAddr = 5'd13; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL reset_cause got %h exp 0", dout); end
    rAddr = 5'd14; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL reset_epc got %h exp 0", dout); end
    rAddr = 5'd9; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got %h exp 0", dout); end
    rAddr = 5'd11; #1; checks++;
    if (dout !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_compare got %h exp ffffffff", dout); end
    rAddr = 5'd20; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL unimpl_read got %h exp 0", dout); end
  endtask

  // Overflow outside a delay slot
  task automatic test_overflow();
    doReset();
    excOverflow = 1'b1; instrPC = 32'h0040_0010; inDelaySlot = 1'b0; #1;
    checks++;
    if (redirect !== 1'b1) begin errors++; $display("[TB] FAIL ov_redirect got %b exp 1", redirect); end
    checks++;
    if (redirectPC !== 32'hBFC0_0380) begin errors++; $display("[TB] FAIL ov_target got %h exp bfc00380", redirectPC); end
    tick();
    applyIdle();
    rAddr = 5'd14; #1; checks++;
    if (dout !== 32'h0040_0010) begin errors++; $display("[TB] FAIL ov_epc got %h exp 00400010", dout); end
    rAddr = 5'd13; #1; checks++;
    if (dout[6:2] !== 5'd12 || dout[31] !== 1'b0) begin
      errors++; $display("[TB] FAIL ov_cause got %h exp exc=12 bd=0", dout);
    end
    rAddr = 5'd12; #1; checks++;
    if (dout[1] !== 1'b1) begin errors++; $display("[TB] FAIL ov_exl got %b exp 1", dout[1]); end
  endtask

  // Syscall in a delay slot, then nested RI and eret
  task automatic test_syscall_nested_eret();
    doReset();
    excSyscall = 1'b1; instrPC = 32'h0040_0020; inDelaySlot = 1'b1;
    tick();
    applyIdle();
    rAddr = 5'd14; #1; checks++;
    if (dout !== 32'h0040_001C) begin errors++; $display("[TB] FAIL sys_epc got %h exp 0040001c", dout); end
    rAddr = 5'd13; #1; checks++;
    if (dout[31] !== 1'b1 || dout[6:2] !== 5'd8) begin
      errors++; $display("[TB] FAIL sys_cause got %h exp bd=1 exc=8", dout);
    end
    excRI = 1'b1; instrPC = 32'h0040_0100; #1; checks++;
    if (redirect !== 1'b1 || redirectPC !== 32'hBFC0_0380) begin
      errors++; $display("[TB] FAIL ri_redirect got %b/%h exp 1/bfc00380", redirect, redirectPC);
    end
    tick();
    applyIdle();
    rAddr = 5'd14; #1; checks++;
    if (dout !== 32'h0040_001C) begin errors++; $display("[TB] FAIL ri_epc_kept got %h exp 0040001c", dout); end
    rAddr = 5'd13; #1; checks++;
    if (dout[6:2] !== 5'd10 || dout[31] !== 1'b1) begin
      errors++; $display("[TB] FAIL ri_cause got %h exp exc=10 bd=1", dout);
    end
    eret = 1'b1; #1; checks++;
    if (redirect !== 1'b1 || redirectPC !== 32'h0040_001C) begin
      errors++; $display("[TB] FAIL eret_redirect got %b/%h exp 1/0040001c", redirect, redirectPC);
    end
    tick();
    applyIdle();
    rAddr = 5'd12; #1; checks++;
    if (dout[1] !== 1'b0) begin errors++; $display("[TB] FAIL eret_exl got %b exp 0", dout[1]); end
  endtask

  // Hardware interrupt, masked afterwards by EXL
  task automatic test_interrupt();
    doReset();
    we = 1'b1; wAddr = 5'd12; din = 32'h0000_0401; rAddr = 5'd12; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL write_old_value got %h exp 0", dout); end
    tick();
    applyIdle();
    intReq = 6'b000001; rAddr = 5'd12; #1; checks++;
    if (dout !== 32'h0000_0401) begin errors++; $display("[TB] FAIL int_status got %h exp 00000401", dout); end
    checks++;
    if (redirect !== 1'b1 || redirectPC !== 32'hBFC0_0380) begin
      errors++; $display("[TB] FAIL int_redirect got %b/%h exp 1/bfc00380", redirect, redirectPC);
    end
    tick();
    rAddr = 5'd13; #1; checks++;
    if (dout[6:2] !== 5'd0 || dout[10] !== 1'b1) begin
      errors++; $display("[TB] FAIL int_cause got %h exp exc=0 ip2=1", dout);
    end
    checks++;
    if (redirect !== 1'b0) begin errors++; $display("[TB] FAIL int_exl_masks got %b exp 0", redirect); end
  endtask

  // Exception beats eret and overlapping mtc0 bits, others still land
  task automatic test_exc_vs_mtc0();
    doReset();
    excBreak = 1'b1; eret = 1'b1; we = 1'b1; wAddr = 5'd12; din = 32'h0000_AB01; #1; checks++;
    if (redirect !== 1'b1 || redirectPC !== 32'hBFC0_0380) begin
      errors++; $display("[TB] FAIL bp_over_eret got %b/%h exp 1/bfc00380", redirect, redirectPC);
    end
    tick();
    applyIdle();
    rAddr = 5'd12; #1; checks++;
    if (dout !== 32'h0000_AB03) begin errors++; $display("[TB] FAIL bp_mtc0_merge got %h exp 0000ab03", dout); end
    rAddr = 5'd13; #1; checks++;
    if (dout[6:2] !== 5'd9) begin errors++; $display("[TB] FAIL bp_code got %0d exp 9", dout[6:2]); end
  endtask

  // Count/Compare match raises TI, Compare write clears it
  task automatic test_timer();
    doReset();
    we = 1'b1; wAddr = 5'd9; din = 32'd5;
    tick();
    wAddr = 5'd11; din = 32'd8;
    tick();
    applyIdle();
    rAddr = 5'd9; #1; checks++;
    if (dout !== 32'd6) begin errors++; $display("[TB] FAIL tmr_count6 got %0d exp 6", dout); end
    rAddr = 5'd13; #1; checks++;
    if (dout[30] !== 1'b0) begin errors++; $display("[TB] FAIL tmr_ti_early got %b exp 0", dout[30]); end
    tick();
    tick();
    rAddr = 5'd9; #1; checks++;
    if (dout !== 32'd8) begin errors++; $display("[TB] FAIL tmr_count8 got %0d exp 8", dout); end
    rAddr = 5'd13; #1; checks++;
    if (dout[30] !== 1'b1 || dout[15] !== 1'b1) begin
      errors++; $display("[TB] FAIL tmr_ti_set got %h exp ti=1 ip7=1", dout);
    end
    we = 1'b1; wAddr = 5'd11; din = 32'd100;
    tick();
    applyIdle();
    rAddr = 5'd13; #1; checks++;
    if (dout[30] !== 1'b0) begin errors++; $display("[TB] FAIL tmr_ti_clear got %b exp 0", dout[30]); end
  endtask

  // Count wraps from all-ones to zero
  task automatic test_count_wrap();
    doReset();
    we = 1'b1; wAddr = 5'd9; din = 32'hFFFF_FFFF;
    tick();
    applyIdle();
    rAddr = 5'd13; #1; checks++;
    if (dout[30] !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ti got %b exp 1", dout[30]); end
    tick();
    rAddr = 5'd9; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL wrap_count got %h exp 0", dout); end
  endtask

  // Stall and reset both suppress redirect and register updates
  task automatic test_stall_reset();
    doReset();
    excOverflow = 1'b1; instrPC = 32'h0040_0040;
    tick();
    applyIdle();
    stall = 1'b1; excOverflow = 1'b1; eret = 1'b1; we = 1'b1; wAddr = 5'd14; din = 32'hDEAD_BEEF; #1; checks++;
    if (redirect !== 1'b0) begin errors++; $display("[TB] FAIL stall_redirect got %b exp 0", redirect); end
    tick();
    applyIdle();
    rAddr = 5'd14; #1; checks++;
    if (dout !== 32'h0040_0040) begin errors++; $display("[TB] FAIL stall_epc got %h exp 00400040", dout); end
    rAddr = 5'd12; #1; checks++;
    if (dout !== 32'h0000_0002) begin errors++; $display("[TB] FAIL stall_status got %h exp 00000002", dout); end
    rAddr = 5'd13; #1; checks++;
    if (dout !== 32'h0000_0030) begin errors++; $display("[TB] FAIL stall_cause got %h exp 00000030", dout); end
    rAddr = 5'd9; #1; checks++;
    if (dout !== 32'd2) begin errors++; $display("[TB] FAIL stall_count got %0d exp 2", dout); end
    rstn = 1'b0; excBreak = 1'b1; eret = 1'b1; we = 1'b1; wAddr = 5'd12; din = 32'h0000_FF03; #1; checks++;
    if (redirect !== 1'b0) begin errors++; $display("[TB] FAIL rst_redirect got %b exp 0", redirect); end
    tick();
    applyIdle();
    rAddr = 5'd14; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL rst_epc got %h exp 0", dout); end
    rAddr = 5'd12; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL rst_status got %h exp 0", dout); end
    rAddr = 5'd9; #1; checks++;
    if (dout !== 32'd0) begin errors++; $display("[TB] FAIL rst_count got %h exp 0", dout); end
  endtask

  // Randomized traffic against the model
  task automatic test_random();
    logic [4:0] addrs [6];
    logic       expRedirect;
    logic [31:0] expPC, expDout;
    addrs[0] = 5'd9; addrs[1] = 5'd11; addrs[2] = 5'd12;
    addrs[3] = 5'd13; addrs[4] = 5'd14; addrs[5] = 5'd3;
    doReset();
    for (int i = 0; i < 600; i++) begin
      rstn        = ($urandom_range(0, 59) != 0);
      excOverflow = ($urandom_range(0, 15) == 0);
      excSyscall  = ($urandom_range(0, 19) == 0);
      excBreak    = ($urandom_range(0, 19) == 0);
      excRI       = ($urandom_range(0, 19) == 0);
      intReq      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      instrPC     = {$urandom, 2'b00} ;
      inDelaySlot = $urandom_range(0, 1) == 1;
      stall       = ($urandom_range(0, 3) == 0);
      eret        = ($urandom_range(0, 5) == 0);
      we          = ($urandom_range(0, 2) == 0);
      wAddr       = addrs[$urandom_range(0, 5)];
      din         = (wAddr == 5'd9 || wAddr == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
      rAddr       = addrs[$urandom_range(0, 5)];
      #1;
      expRedirect = mTakeExc() || mTakeEret();
      expPC       = mTakeExc() ? 32'hBFC0_0380 : mEpc;
      expDout     = mRead(rAddr);
      checks++;
      if (redirect !== expRedirect) begin
        errors++; $display("[TB] FAIL rnd_redirect it=%0d got %b exp %b", i, redirect, expRedirect);
      end
      if (expRedirect) begin
        checks++;
        if (redirectPC !== expPC) begin
          errors++; $display("[TB] FAIL rnd_target it=%0d got %h exp %h", i, redirectPC, expPC);
        end
      end
      checks++;
      if (dout !== expDout) begin
        errors++; $display("[TB] FAIL rnd_dout it=%0d addr=%0d got %h exp %h", i, rAddr, dout, expDout);
      end
      tick();
    end
  endtask

  initial begin
    applyIdle();
    $display("[TB] starting cp0_unit bench");
    test_reset();
    test_overflow();
    test_syscall_nested_eret();
    test_interrupt();
    test_exc_vs_mtc0();
    test_timer();
    test_count_wrap();
    test_stall_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380, the exception redirect target.
REQ-002 SHALL have parameter RESET_STATUS, default 32'h0000_0000, the Status value loaded at reset (writable bits only).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous and active-low.
REQ-005 SHALL have ports excOverflow / excSyscall / excBreak / excRI  in  1 each  synchronous exceptions flagged by the EX-stage instruction (excOverflow comes from the ALU exception output).
REQ-006 SHALL have port intReq  in  6  level hardware interrupt lines HW0..HW5.
REQ-007 SHALL have ports instrPC  in  32 (PC of the EX-stage instruction) and inDelaySlot  in  1 (that instruction is in a branch delay slot).
REQ-008 SHALL have port stall  in  1  EX stage held; suppresses exception entry, mtc0 and eret.
REQ-009 SHALL have ports we  in  1, wAddr  in  5, din  in  32  mtc0 write.
REQ-010 SHALL have ports rAddr  in  5, dout  out  32  mfc0 read.
REQ-011 SHALL have port eret  in  1  EX-stage instruction is eret.
REQ-012 SHALL have ports redirect  out  1 (flush and refetch) and redirectPC  out  32 (fetch target).

Function
REQ-013 SHALL implement Count (9), Compare (11), Status (12), Cause (13) and EPC (14); other addresses read 0 and ignore writes.
REQ-014 Status fields SHALL be IM[15:8], EXL[1], IE[0]; other bits read 0.
REQ-015 Cause fields SHALL be BD[31], TI[30], IP[15:8], ExcCode[6:2]; other bits read 0.
REQ-016 Writes through mtc0 SHALL change only Status IM/EXL/IE, Cause IP[9:8], and all of EPC, Count and Compare.
REQ-017 Cause IP[15:10] SHALL mirror intReq every cycle, with IP[15] = intReq[5] | TI.
REQ-018 An interrupt SHALL be pending when IE=1 and EXL=0 and (IP & IM) != 0.
REQ-019 Source priority SHALL be interrupt > RI (ExcCode 10) > Syscall (8) > Break (9) > Overflow (12); interrupt ExcCode is 0.
REQ-020 When stall=0 and any source is active, redirect=1 and redirectPC=EXC_VECTOR SHALL be driven in the same cycle (combinational).
REQ-021 At the edge after such a cycle, the block SHALL set ExcCode and EXL=1, and if EXL was 0 also set BD=inDelaySlot and EPC = inDelaySlot ? instrPC-4 : instrPC.
REQ-022 If EXL was already 1, EPC and BD SHALL be left unchanged; ExcCode SHALL still update.
REQ-023 For eret with stall=0 and no exception, redirect=1 and redirectPC=EPC SHALL be driven, and EXL SHALL clear at the next edge.
REQ-024 Exception SHALL win over simultaneous eret; exception fields SHALL win over a simultaneous mtc0 to the same field; non-overlapping mtc0 bits SHALL still commit.
REQ-025 dout SHALL be a combinational read of current register state; a same-cycle write SHALL return the old value.
REQ-026 Count SHALL increment by 1 each cycle regardless of stall and wrap 32'hFFFF_FFFF -> 0; an mtc0 to Count SHALL load din instead of incrementing.
REQ-027 TI SHALL set on the edge where the next Count value equals Compare, and SHALL clear on any mtc0 to Compare (that write wins over a same-edge match).
REQ-028 redirect SHALL be 0 whenever stall=1 or rstn=0.

Reset
REQ-029 With rstn=0 at an edge, the block SHALL load Status=RESET_STATUS (masked), Cause=0, EPC=0, Count=0 and Compare=32'hFFFF_FFFF.
REQ-030 Reset SHALL override every same-cycle exception, eret and mtc0.

Structure
REQ-031 Package cp0_pkg SHALL hold the register addresses, the ExcCode constants and the field bit positions.
REQ-032 Count, Compare and TI SHALL be in a single sub-module, cp0_timer.

Verification
REQ-033 Bench SHALL cover: excOverflow=1, instrPC=32'h0040_0010, inDelaySlot=0 -> same cycle redirect=1 and redirectPC=32'hBFC0_0380; next cycle EPC=32'h0040_0010, ExcCode=12, EXL=1, BD=0.
REQ-034 Bench SHALL cover: excSyscall=1 with inDelaySlot=1 and instrPC=32'h0040_0020 -> EPC=32'h0040_001C, BD=1, ExcCode=8.
REQ-035 Bench SHALL cover: a second excRI while EXL=1 -> EPC unchanged, ExcCode=10; then eret -> redirectPC=old EPC, and EXL=0 next cycle.
REQ-036 Bench SHALL cover: Status=32'h0000_0401 and intReq[0]=1 -> interrupt taken with ExcCode=0; same input with Status.EXL=1 -> no redirect.
REQ-037 Bench SHALL cover: mtc0 Count=5 then Compare=8 -> TI=1 when Count reaches 8; mtc0 Compare -> TI=0.
REQ-038 Bench SHALL cover: stall=1 with excOverflow=1, and rstn=0 with excBreak=1 -> redirect=0 and no register change except Count (which resets to 0 under rstn=0).
